cache_fill_ctrl: RTL and testbench
==================================

# cache_fill_ctrl

Miss-handling controller that shares the single main-memory read port between the instruction cache and the data cache. It arbitrates between the two miss requests and streams the 8-word (16-byte) block from memory. It drives each cache's FSM-side write port (data words, then one metadata write) and releases the cache to re-probe. It sits between both cache instances and the memory model in the CPU memory subsystem.

## Interface
- No parameters. Block = 8 words × 16 bits; memory read latency is not fixed, and the block tracks returns only through `mem_valid`.
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `miss_I` in 1: I-cache miss, held high until the block is filled.
- `addr_I` in 16: I-cache miss address.
- `miss_D` in 1: D-cache miss, held high until the block is filled.
- `addr_D` in 16: D-cache miss address.
- `mem_data` in 16: memory read data.
- `mem_valid` in 1: `mem_data` valid this cycle; one pulse per issued read, in issue order.
- `mem_en` out 1: memory read request, one word per cycle.
- `mem_addr` out 16: memory read address.
- `DataIn_FSM` out 16: fill data to both caches; a combinational pass of `mem_data`.
- `Addr_FSM` out 16: fill word address to both caches.
- `Data_WE_I` / `Data_WE_D` out 1 each: word write enable to the I-cache / D-cache.
- `MetaData_WE_I` / `MetaData_WE_D` out 1 each: metadata write enable to the I-cache / D-cache.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States are IDLE, FILL, META and HOLD.
- **IDLE**
  - Sample `miss_I` and `miss_D`.
  - If exactly one is high, grant it.
  - If both are high, grant the one not served last. After reset, D wins the first tie.
  - On grant, latch the block base `{addr_x[15:4],4'b0}` and the grant select `gnt` (0=I, 1=D). Clear `iss_cnt` and `ret_cnt`, then go to FILL.
- **FILL: issue side**
  - While `iss_cnt < 8`: `mem_en=1`, `mem_addr = {base[15:4], iss_cnt[2:0], 1'b0}`, then increment `iss_cnt`.
  - `iss_cnt` is 4 bits and saturates at 8.
- **FILL: return side**
  - On each `mem_valid`: `Data_WE_gnt=1`, `Addr_FSM = {base[15:4], ret_cnt[2:0], 1'b0}`, `DataIn_FSM = mem_data`, then increment `ret_cnt`.
  - Issue and return may occur in the same cycle.
  - When `mem_valid` arrives with `ret_cnt==7`, go to META.
- **META**: one cycle. `MetaData_WE_gnt=1`, `Addr_FSM = base`. Then go to HOLD.
- **HOLD**: one cycle with all enables low, so the caches' registered metadata write can retire. Then go to IDLE. The served cache's `miss` is ignored during HOLD.
- The non-granted cache's write enables are never asserted.
- `mem_valid` outside FILL is ignored, and so is any `mem_valid` beyond 8 returns.
- Changes on `addr_x` or `miss_x` after grant are ignored. A fill always runs to completion, even if `miss_x` drops.
- `Addr_FSM` idles at `base`, and `DataIn_FSM` always mirrors `mem_data`.

## Timing
- **Reset values**: state IDLE; `mem_en`, `mem_addr`, `Addr_FSM`, all WE outputs and `busy` are 0; `gnt`, `base` and the counters are 0; the tie-break points to D. `DataIn_FSM` follows `mem_data`.
- **Reset during FILL**: the block enters IDLE immediately, no further enables are asserted, and late returns are dropped because `mem_valid` is ignored in IDLE.
- **Grant to first request**: the miss is seen in IDLE at cycle 0 and `mem_en` goes high at cycle 1.
- **Issue**: 8 consecutive `mem_en` cycles, cycles 1–8.
- **Returns with a 4-cycle memory**: `Data_WE` in cycles 5–12, META in cycle 13, HOLD in cycle 14, IDLE in cycle 15. A waiting second miss is granted in cycle 15.
- The fill is latency-independent. Gaps in `mem_valid` stall only the return side.
- All state, counters and address outputs are registered. The WE outputs and `Addr_FSM` are decoded from state and `mem_valid`, and are asserted in the same cycle as `mem_valid`.

## Test plan
- **I miss only**: `miss_I=1`, `addr_I=0x3A56`, 4-cycle memory returning the word index.
  - `mem_addr` = 0x3A50, 0x3A52, … 0x3A5E in cycles 1–8.
  - `Data_WE_I` in cycles 5–12 with matching `Addr_FSM`.
  - `MetaData_WE_I` in cycle 13 with `Addr_FSM`=0x3A50.
  - `Data_WE_D` stays 0 throughout.
- **Simultaneous misses after reset**: `miss_I`=`miss_D`=1.
  - D is filled first.
  - I is granted in cycle 15.
  - A third tie after that goes to D (round-robin check).
- **Irregular latency**: `mem_valid` returns with random gaps of 0–5 cycles.
  - Exactly 8 `Data_WE` pulses with word addresses in order.
  - One `MetaData_WE`, asserted after the 8th return.
- **Miss deasserted mid-fill**: `miss_D` drops in cycle 3.
  - The fill still completes with 8 data writes and one metadata write.
- **Reset in cycle 7 of a fill**: `rst_n=0`.
  - All outputs go to 0 asynchronously.
  - After release, the pending returns' `mem_valid` pulses cause no WE.
- **HOLD masking**: `miss_I` is kept high through HOLD.
  - No re-grant in cycle 14.
  - I is re-granted in cycle 15 only if `miss_I` is still high there.

Source files
------------

// File: rtl/cache_fill_ctrl_if.sv
// Signal bundle shared by the fill controller, both caches' FSM-side write ports
// and the main-memory read port.
interface cache_fill_ctrl_if;
  logic        miss_I;
  logic [15:0] addr_I;
  logic        miss_D;
  logic [15:0] addr_D;
  logic [15:0] mem_data;
  logic        mem_valid;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [15:0] DataIn_FSM;
  logic [15:0] Addr_FSM;
  logic        Data_WE_I;
  logic        Data_WE_D;
  logic        MetaData_WE_I;
  logic        MetaData_WE_D;
  logic        busy;

  modport master (
    input  miss_I, addr_I, miss_D, addr_D, mem_data, mem_valid,
    output mem_en, mem_addr, DataIn_FSM, Addr_FSM,
           Data_WE_I, Data_WE_D, MetaData_WE_I, MetaData_WE_D, busy
  );

  modport slave (
    output miss_I, addr_I, miss_D, addr_D, mem_data, mem_valid,
    input  mem_en, mem_addr, DataIn_FSM, Addr_FSM,
           Data_WE_I, Data_WE_D, MetaData_WE_I, MetaData_WE_D, busy
  );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Shares one memory read port between I- and D-cache misses: round-robin grant,
// 8-word block streaming into the granted cache, then one metadata write.
module cache_fill_ctrl (
  input  logic              clk,
  input  logic              rst_n,
  cache_fill_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, FILL, META, HOLD} state_t;

  state_t      state_reg, state_next;
  logic        gnt_reg, gnt_next;
  logic        prio_d_reg, prio_d_next;
  logic [15:0] base_reg, base_next;
  logic [3:0]  iss_cnt_reg, iss_cnt_next;
  logic [3:0]  ret_cnt_reg, ret_cnt_next;
  logic        mem_en_reg, mem_en_next;
  logic [15:0] mem_addr_reg, mem_addr_next;

  logic        data_we;
  logic        meta_we;
  logic [15:0] addr_fsm;
  logic [2:0]  iss_idx_next;
  logic        pick_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      gnt_reg      <= 1'b0;
      prio_d_reg   <= 1'b1;
      base_reg     <= 16'h0000;
      iss_cnt_reg  <= 4'd0;
      ret_cnt_reg  <= 4'd0;
      mem_en_reg   <= 1'b0;
      mem_addr_reg <= 16'h0000;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      prio_d_reg   <= prio_d_next;
      base_reg     <= base_next;
      iss_cnt_reg  <= iss_cnt_next;
      ret_cnt_reg  <= ret_cnt_next;
      mem_en_reg   <= mem_en_next;
      mem_addr_reg <= mem_addr_next;
    end
  end

  // mem_en/mem_addr are registered, so the next request is computed one cycle
  // ahead: the grant itself loads word 0, and each FILL issue loads the next word.
  always_comb begin
    state_next    = state_reg;
    gnt_next      = gnt_reg;
    prio_d_next   = prio_d_reg;
    base_next     = base_reg;
    iss_cnt_next  = iss_cnt_reg;
    ret_cnt_next  = ret_cnt_reg;
    mem_en_next   = 1'b0;
    mem_addr_next = mem_addr_reg;
    data_we       = 1'b0;
    meta_we       = 1'b0;
    addr_fsm      = base_reg;
    iss_idx_next  = iss_cnt_reg[2:0] + 3'd1;
    pick_d        = bus.miss_D & (~bus.miss_I | prio_d_reg);

    case (state_reg)
      IDLE: begin
        if (bus.miss_I | bus.miss_D) begin
          gnt_next      = pick_d;
          base_next     = pick_d ? {bus.addr_D[15:4], 4'h0} : {bus.addr_I[15:4], 4'h0};
          prio_d_next   = ~pick_d;
          iss_cnt_next  = 4'd0;
          ret_cnt_next  = 4'd0;
          mem_en_next   = 1'b1;
          mem_addr_next = base_next;
          state_next    = FILL;
        end
      end

      FILL: begin
        if (iss_cnt_reg < 4'd8) begin
          iss_cnt_next  = iss_cnt_reg + 4'd1;
          mem_en_next   = (iss_cnt_reg < 4'd7);
          mem_addr_next = {base_reg[15:4], iss_idx_next, 1'b0};
        end
        if (bus.mem_valid) begin
          data_we      = 1'b1;
          addr_fsm     = {base_reg[15:4], ret_cnt_reg[2:0], 1'b0};
          ret_cnt_next = ret_cnt_reg + 4'd1;
          if (ret_cnt_reg == 4'd7) begin
            state_next  = META;
            mem_en_next = 1'b0;
          end
        end
      end

      META: begin
        meta_we    = 1'b1;
        state_next = HOLD;
      end

      // Lets the cache's registered metadata write retire before it re-probes.
      HOLD: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.mem_en        = mem_en_reg;
  assign bus.mem_addr      = mem_addr_reg;
  assign bus.DataIn_FSM    = bus.mem_data;
  assign bus.Addr_FSM      = addr_fsm;
  assign bus.Data_WE_I     = data_we & ~gnt_reg;
  assign bus.Data_WE_D     = data_we &  gnt_reg;
  assign bus.MetaData_WE_I = meta_we & ~gnt_reg;
  assign bus.MetaData_WE_D = meta_we &  gnt_reg;
  assign bus.busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Scoreboard bench for cache_fill_ctrl: a driver predicts grants and pushes the
// expected memory requests and cache writes; a negedge monitor pops and compares.
module tb_cache_fill_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_fill_ctrl_if bus ();

  cache_fill_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          meta;
    bit          d;
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    int          due;
    logic [15:0] addr;
  } rd_t;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  wr_t         exp_wr[$];
  logic [15:0] exp_req[$];
  rd_t         pend[$];
  logic [15:0] mem_img [256];
  bit          lat_fixed = 1'b1;
  int          last_due = 0;
  int          meta_cnt = 0;
  int          meta_cyc = 0;
  int          first_req_cyc = 0;
  int          we_total = 0;
  bit          rr_d = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference rule: a lone miss wins; on a tie the cache not served last wins.
  task automatic pick(output bit d);
    if (bus.miss_I && bus.miss_D) d = rr_d;
    else d = bus.miss_D;
    rr_d = !d;
  endtask

  task automatic expect_fill(input bit d, input logic [15:0] a);
    logic [15:0] b;
    wr_t w;
    b = a & 16'hFFF0;
    for (int i = 0; i < 8; i++) begin
      exp_req.push_back(b + 16'(2 * i));
      w.meta = 1'b0;
      w.d    = d;
      w.addr = b + 16'(2 * i);
      w.data = mem_img[w.addr[8:1]];
      exp_wr.push_back(w);
    end
    w.meta = 1'b1;
    w.d    = d;
    w.addr = b;
    w.data = 16'h0000;
    exp_wr.push_back(w);
    $display("fill expected: cache=%s base=0x%h", d ? "D" : "I", b);
  endtask

  task automatic wait_meta(input int target);
    int n;
    n = 0;
    while (meta_cnt < target && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (meta_cnt < target) chk("meta_timeout", 32'(meta_cnt), 32'(target));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 100) begin
      tick(1);
      n++;
    end
    if (bus.busy) chk("idle_timeout", 32'(bus.busy), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_req.delete();
    exp_wr.delete();
    rr_d = 1'b1;
    bus.miss_I = 1'b0;
    bus.miss_D = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  // Serves every pending miss; called in the cycle the misses are first presented.
  task automatic run_chain(input int reraise_pct, input bit perturb);
    int g, m, guard, target;
    bit d, first;
    g = cyc;
    m = 0;
    guard = 0;
    first = 1'b1;
    while ((bus.miss_I || bus.miss_D) && guard < 8) begin
      pick(d);
      expect_fill(d, d ? bus.addr_D : bus.addr_I);
      guard++;
      target = meta_cnt + 1;
      if (perturb) begin
        tick(3);
        if (d) bus.addr_D = 16'($urandom);
        else bus.addr_I = 16'($urandom);
      end
      wait_meta(target);
      if (first) chk("grant_latency", 32'(first_req_cyc), 32'(g + 1));
      else chk("regrant_after_hold", 32'(first_req_cyc), 32'(m + 3));
      first = 1'b0;
      m = meta_cyc;
      tick(1);
      if (d) bus.miss_D = 1'b0;
      else bus.miss_I = 1'b0;
      if (guard < 4 && $urandom_range(0, 99) < reraise_pct) begin
        if (d) begin
          bus.miss_D = 1'b1;
          bus.addr_D = 16'($urandom);
        end else begin
          bus.miss_I = 1'b1;
          bus.addr_I = 16'($urandom);
        end
      end
    end
    wait_idle();
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Memory model: in-order returns, fixed 4-cycle latency or random 0-5 cycle gaps.
  initial begin
    int due;
    bus.mem_valid = 1'b0;
    bus.mem_data  = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_en) begin
        if (lat_fixed) begin
          due = cyc + 4;
        end else begin
          due = (cyc + 1 > last_due + 1) ? cyc + 1 : last_due + 1;
          due = due + int'($urandom_range(0, 5));
        end
        last_due = due;
        pend.push_back('{due: due, addr: bus.mem_addr});
      end
      bus.mem_valid = 1'b0;
      bus.mem_data  = 16'($urandom);
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        bus.mem_valid = 1'b1;
        bus.mem_data  = mem_img[pend[0].addr[8:1]];
        void'(pend.pop_front());
      end else if (!bus.busy && $urandom_range(0, 7) == 0) begin
        bus.mem_valid = 1'b1;
      end
    end
  end

  // Monitor: every request and every cache write must match the head of its queue.
  initial begin
    logic [3:0]  we, ew;
    logic [15:0] a;
    wr_t         e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.mem_en) begin
          if (exp_req.size() == 0) begin
            chk("stray_mem_en", 32'(bus.mem_en), 32'd0);
          end else begin
            a = exp_req.pop_front();
            chk("mem_addr", 32'(bus.mem_addr), 32'(a));
            if (a[3:0] == 4'h0) first_req_cyc = cyc;
          end
        end
        we = {bus.MetaData_WE_I, bus.MetaData_WE_D, bus.Data_WE_I, bus.Data_WE_D};
        if (we != 4'b0000) begin
          we_total++;
          if (exp_wr.size() == 0) begin
            chk("stray_we", 32'(we), 32'd0);
          end else begin
            e  = exp_wr.pop_front();
            ew = e.meta ? (e.d ? 4'b0100 : 4'b1000) : (e.d ? 4'b0001 : 4'b0010);
            chk("we_select", 32'(we), 32'(ew));
            chk("addr_fsm", 32'(bus.Addr_FSM), 32'(e.addr));
            if (!e.meta) chk("fill_data", 32'(bus.DataIn_FSM), 32'(e.data));
            if (e.meta) begin
              meta_cnt++;
              meta_cyc = cyc;
              $display("meta write: cache=%s base=0x%h cycle=%0d",
                       e.d ? "D" : "I", e.addr, cyc);
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int  g, m, w0, target;
    bit  d;
    logic [1:0] r;

    for (int i = 0; i < 256; i++) mem_img[i] = 16'($urandom);
    bus.miss_I = 1'b0;
    bus.miss_D = 1'b0;
    bus.addr_I = 16'h0000;
    bus.addr_D = 16'h0000;

    // Reset state
    tick(2);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_addr_fsm", 32'(bus.Addr_FSM), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_we", 32'({bus.Data_WE_I, bus.Data_WE_D, bus.MetaData_WE_I, bus.MetaData_WE_D}), 32'd0);
    chk("rst_datain_pass", 32'(bus.DataIn_FSM), 32'(bus.mem_data));
    rst_n = 1'b1;
    tick(2);

    // I miss only, 4-cycle memory
    lat_fixed = 1'b1;
    g = cyc;
    bus.addr_I = 16'h3A56;
    bus.miss_I = 1'b1;
    pick(d);
    expect_fill(d, bus.addr_I);
    wait_meta(meta_cnt + 1);
    chk("t1_first_req_cyc", 32'(first_req_cyc), 32'(g + 1));
    chk("t1_meta_cyc", 32'(meta_cyc), 32'(g + 13));
    tick(1);
    bus.miss_I = 1'b0;
    @(negedge clk);
    chk("t1_busy_in_hold", 32'(bus.busy), 32'd1);
    tick(1);
    @(negedge clk);
    chk("t1_idle_cycle15", 32'(bus.busy), 32'd0);
    chk("t1_addr_fsm_idle", 32'(bus.Addr_FSM), 32'h3A50);
    tick(1);

    // Simultaneous misses after reset: D, then I, then a new tie goes to D
    do_reset();
    bus.addr_I = 16'($urandom);
    bus.addr_D = 16'($urandom);
    bus.miss_I = 1'b1;
    bus.miss_D = 1'b1;
    run_chain(0, 1'b0);
    bus.addr_I = 16'($urandom);
    bus.addr_D = 16'($urandom);
    bus.miss_I = 1'b1;
    bus.miss_D = 1'b1;
    run_chain(0, 1'b0);

    // Miss deasserted mid-fill
    g = cyc;
    bus.addr_D = 16'($urandom);
    bus.miss_D = 1'b1;
    pick(d);
    expect_fill(d, bus.addr_D);
    target = meta_cnt + 1;
    tick(3);
    bus.miss_D = 1'b0;
    wait_meta(target);
    chk("t4_meta_cyc", 32'(meta_cyc), 32'(g + 13));
    wait_idle();

    // Reset in cycle 7 of a fill; late returns must not write
    g = cyc;
    bus.addr_D = 16'($urandom);
    bus.miss_D = 1'b1;
    pick(d);
    expect_fill(d, bus.addr_D);
    tick(7);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("t5_rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("t5_rst_addr_fsm", 32'(bus.Addr_FSM), 32'd0);
    chk("t5_rst_busy", 32'(bus.busy), 32'd0);
    chk("t5_rst_we", 32'({bus.Data_WE_I, bus.Data_WE_D, bus.MetaData_WE_I, bus.MetaData_WE_D}), 32'd0);
    exp_req.delete();
    exp_wr.delete();
    rr_d = 1'b1;
    bus.miss_D = 1'b0;
    w0 = we_total;
    tick(2);
    rst_n = 1'b1;
    tick(12);
    chk("t5_no_we_after_reset", 32'(we_total - w0), 32'd0);
    chk("t5_busy_after_reset", 32'(bus.busy), 32'd0);

    // HOLD masking: I kept high through HOLD, re-granted in cycle 15
    g = cyc;
    bus.addr_I = 16'($urandom);
    bus.miss_I = 1'b1;
    pick(d);
    expect_fill(d, bus.addr_I);
    wait_meta(meta_cnt + 1);
    m = meta_cyc;
    tick(1);
    @(negedge clk);
    chk("t6_busy_hold", 32'(bus.busy), 32'd1);
    pick(d);
    expect_fill(d, bus.addr_I);
    target = meta_cnt + 1;
    tick(1);
    @(negedge clk);
    chk("t6_no_regrant_in_hold", 32'(bus.mem_en), 32'd0);
    wait_meta(target);
    chk("t6_regrant_cyc", 32'(first_req_cyc), 32'(m + 3));
    tick(1);
    bus.miss_I = 1'b0;
    wait_idle();
    tick(4);
    chk("t6_no_regrant_after_drop", 32'(bus.busy), 32'd0);

    // Randomized misses, addresses and memory latency
    for (int ep = 0; ep < 25; ep++) begin
      lat_fixed = 1'($urandom_range(0, 1));
      r = 2'($urandom_range(1, 3));
      bus.addr_I = 16'($urandom);
      bus.addr_D = 16'($urandom);
      bus.miss_I = r[0];
      bus.miss_D = r[1];
      run_chain(30, 1'b1);
      tick($urandom_range(0, 3));
    end

    tick(10);
    chk("exp_req_drained", 32'(exp_req.size()), 32'd0);
    chk("exp_wr_drained", 32'(exp_wr.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
